// File: rtl/pingpong_pkg.sv
// rtl/pingpong_pkg.sv - shared types and constants for the ping-pong write scheduler
package pingpong_pkg;

  typedef enum logic [1:0] {FREE, FILLING, READY} bank_state_t;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DROP} fsm_t;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/pingpong_wr_ctrl_toggle_sync.sv
// rtl/pingpong_wr_ctrl_toggle_sync.sv - 2-flop toggle synchronizer with edge-detect pulse
module toggle_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl_i,
  output logic pulse_o
);

  // sync_q[0..1] are the metastability flops, sync_q[2] holds the previous synced level
  logic [2:0] sync_q;

  // shift the foreign toggle through the synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], tgl_i};
    end
  end

  assign pulse_o = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/pingpong_wr_ctrl.sv
// rtl/pingpong_wr_ctrl.sv - write-side bank scheduler for the two package buffers
module pingpong_wr_ctrl
  import pingpong_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int PACKAGE_SIZE = 4864,
  parameter int CNT_WIDTH    = 14
) (
  input  logic                  rst_n,
  input  logic                  wr_clk,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  rd_done_tgl_a,
  input  logic                  rd_done_tgl_b,
  output logic                  wr_en_a,
  output logic                  wr_en_b,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  intr_req,
  output logic                  ready_bank,
  output logic                  overflow,
  output logic                  pkt_err,
  output logic [15:0]           pkt_cnt
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(PACKAGE_SIZE - 1);

  fsm_t                  state_q, state_d;
  bank_state_t           bank_q [2];
  bank_state_t           bank_d [2];
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  nxt_q, nxt_d;
  logic                  cur_q, cur_d;
  logic                  first_q, first_d;
  logic                  pv_q;
  logic [1:0]            wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  ovf_q, ovf_d;
  logic                  perr_q, perr_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d;
  logic [1:0]            rel;
  logic                  go;

  toggle_sync u_sync_a (.clk(wr_clk), .rst_n(rst_n), .tgl_i(rd_done_tgl_a), .pulse_o(rel[BANK_A]));
  toggle_sync u_sync_b (.clk(wr_clk), .rst_n(rst_n), .tgl_i(rd_done_tgl_b), .pulse_o(rel[BANK_B]));

  // next-state: bank selection, fill counting, release, and frame abort
  always_comb begin
    state_d   = state_q;
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    cnt_d     = cnt_q;
    nxt_d     = nxt_q;
    cur_d     = cur_q;
    first_d   = first_q;
    wr_en_d   = 2'b00;
    ovf_d     = ovf_q;
    perr_d    = perr_q;
    pkt_cnt_d = pkt_cnt_q;
    go        = 1'b0;

    // a release only frees a bank whose registered state is READY
    for (int i = 0; i < 2; i++) begin
      if (rel[i] && bank_q[i] == READY) bank_d[i] = FREE;
    end

    if (frame_start) begin
      for (int i = 0; i < 2; i++) begin
        if (bank_q[i] == FILLING) bank_d[i] = FREE;
      end
      state_d   = S_IDLE;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      perr_d    = 1'b0;
      pkt_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pix_valid && !pv_q) begin
            if (bank_q[nxt_q] == FREE) begin
              cur_d = nxt_q;
              go    = 1'b1;
            end else if (bank_q[~nxt_q] == FREE) begin
              cur_d = ~nxt_q;
              go    = 1'b1;
            end
            if (go) begin
              bank_d[cur_d]  = FILLING;
              wr_en_d[cur_d] = 1'b1;
              cnt_d          = CNT_WIDTH'(1);
              state_d        = S_FILL;
            end else begin
              ovf_d   = 1'b1;
              state_d = S_DROP;
            end
          end
        end
        S_FILL: begin
          if (pix_valid) begin
            wr_en_d[cur_q] = 1'b1;
            if (cnt_q == LAST_CNT) begin
              bank_d[cur_q] = READY;
              cnt_d         = '0;
              pkt_cnt_d     = (pkt_cnt_q == 16'hFFFF) ? pkt_cnt_q : pkt_cnt_q + 16'd1;
              nxt_d         = ~cur_q;
              state_d       = S_IDLE;
              // the other bank stays first in line unless it leaves READY this cycle
              first_d       = (bank_q[~cur_q] == READY && !rel[~cur_q]) ? ~cur_q : cur_q;
            end else begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
          end else begin
            bank_d[cur_q] = FREE;
            perr_d        = 1'b1;
            cnt_d         = '0;
            state_d       = S_IDLE;
          end
        end
        S_DROP: begin
          if (!pix_valid) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state and registered output flops
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bank_q[0] <= FREE;
      bank_q[1] <= FREE;
      cnt_q     <= '0;
      nxt_q     <= BANK_A;
      cur_q     <= BANK_A;
      first_q   <= BANK_A;
      pv_q      <= 1'b0;
      wr_en_q   <= 2'b00;
      din_q     <= '0;
      ovf_q     <= 1'b0;
      perr_q    <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      cnt_q     <= cnt_d;
      nxt_q     <= nxt_d;
      cur_q     <= cur_d;
      first_q   <= first_d;
      pv_q      <= pix_valid;
      wr_en_q   <= wr_en_d;
      din_q     <= pix_data;
      ovf_q     <= ovf_d;
      perr_q    <= perr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign wr_en_a    = wr_en_q[BANK_A];
  assign wr_en_b    = wr_en_q[BANK_B];
  assign din        = din_q;
  assign intr_req   = (bank_q[BANK_A] == READY) || (bank_q[BANK_B] == READY);
  assign ready_bank = (bank_q[BANK_A] == READY && bank_q[BANK_B] == READY) ? first_q
                                                                           : (bank_q[BANK_B] == READY);
  assign overflow   = ovf_q;
  assign pkt_err    = perr_q;
  assign pkt_cnt    = pkt_cnt_q;

endmodule
